// File: rtl/hci_thld_queue.sv
// Single-clock FIFO with first-word fall-through read and a programmable
// threshold trigger. The trigger counts either occupied entries (consumer-side
// queues) or free slots (producer-side queues).
module hci_thld_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int THLD_WIDTH = 8,
    parameter int LIMIT_FREE = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic                        wvalid_i,
    output logic                        wready_o,
    input  logic [DATA_WIDTH-1:0]       wdata_i,
    output logic                        rvalid_o,
    input  logic                        rready_i,
    output logic [DATA_WIDTH-1:0]       rdata_o,
    input  logic [THLD_WIDTH-1:0]       thld_i,
    output logic                        thld_trig_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Common width for comparing the threshold against count or free slots.
    localparam int MW = (THLD_WIDTH > CW) ? THLD_WIDTH : CW;

    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  pop;
    logic [MW-1:0]         eff_thld;
    logic [MW-1:0]         level;

    // A zero threshold means "any one entry"; anything above DEPTH saturates
    // to DEPTH so the trigger stays reachable.
    function automatic logic [MW-1:0] eff_thld_f(input logic [THLD_WIDTH-1:0] t);
        logic [MW-1:0] tw;
        tw = MW'(t);
        if (tw == '0) begin
            return MW'(1);
        end else if (tw > MW'(DEPTH)) begin
            return MW'(DEPTH);
        end else begin
            return tw;
        end
    endfunction

    assign full_o   = (count == CW'(DEPTH));
    assign empty_o  = (count == '0);
    assign count_o  = count;
    // wready_o deliberately ignores rready_i: a full queue refuses a push even
    // when the same cycle pops, keeping the read path out of the write path.
    assign wready_o = !full_o;
    assign rvalid_o = !empty_o;
    assign push     = wvalid_i && wready_o;
    assign pop      = rvalid_o && rready_i;

    // Head entry is presented directly; an empty queue shows zero.
    always_comb begin
        rdata_o = '0;
        if (!empty_o) begin
            rdata_o = ram[rptr];
        end
    end

    // Threshold compare against occupancy or free slots; thld_i acts immediately.
    always_comb begin
        eff_thld = eff_thld_f(thld_i);
        level    = MW'(count);
        if (LIMIT_FREE != 0) begin
            level = MW'(CW'(DEPTH) - count);
        end
        thld_trig_o = (level >= eff_thld);
    end

    // Pointer and occupancy state; flush behaves exactly like reset and
    // discards any handshake in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage write; the array itself carries no reset.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i && !clr_i) begin
            ram[wptr] <= wdata_i;
        end
    end

    // Guard the handshake rules and the occupancy bound.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && full_o));
            assert (!(pop && empty_o));
            assert (count <= CW'(DEPTH));
        end
    end

endmodule
